lab1_gate_checker: RTL and testbench

Self-checking sequencer for the NAND-built AND/OR/NOT gate stage (lab1_2_iii). On `start`, it drives all four {A,B} input combinations into the gate stage, waits a programmable settle time for each, and samples the three gate outputs. It compares them against golden values and reports a per-vector, per-gate error mask, an error count and a pass flag. It sits both upstream (it drives inA/inB) and downstream (it consumes outAND/outOR/outNOT) of the gate stage, and serves as the on-board self-test for the lab.

---
 rtl/lab1_gate_checker_pkg.sv | 28 ++
 rtl/lab1_gate_checker_golden.sv | 16 +
 rtl/lab1_gate_checker.sv | 126 ++++++++++++
 tb/tb_lab1_gate_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_gate_checker_pkg.sv
// Shared definitions for the lab1 gate-stage self-test sequencer.
//   state_t      : sequencer FSM states
//   G_*          : bit position of each gate inside a per-vector 3-bit group
//   NUM_VECS     : number of {A,B} input combinations driven per run
//   count_ones3  : mismatch count of one vector (0..3), widened for errCount
package lab1_gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int G_AND     = 0;
  localparam int G_OR      = 1;
  localparam int G_NOT     = 2;
  localparam int NUM_GATES = 3;
  localparam int NUM_VECS  = 4;
  localparam int MASK_W    = NUM_VECS * NUM_GATES;

  localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

  function automatic logic [3:0] count_ones3(input logic [2:0] v);
    return 4'(v[0]) + 4'(v[1]) + 4'(v[2]);
  endfunction

endpackage

// File: rtl/lab1_gate_checker_golden.sv
// Combinational reference model of the NAND-built gate stage.
//   a, b     : gate stage inputs (inA, inB)
//   expected : golden outputs packed as {NOT, OR, AND}
module lab1_gate_checker_golden
  import lab1_gate_checker_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [2:0] expected
);

  assign expected[G_AND] = a & b;
  assign expected[G_OR]  = a | b;
  assign expected[G_NOT] = ~a;

endmodule

// File: rtl/lab1_gate_checker.sv
// On-board self-test for the lab1 AND/OR/NOT gate stage.
// On start it walks {A,B} through 00,01,10,11, holds each vector for
// SETTLE_CYCLES cycles, then spends one CHECK cycle comparing the sampled
// gate outputs against the golden model and accumulating the result.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start                 : run request, only looked at while idle
//   drvA, drvB            : registered drive into gate stage inA / inB
//   smpAND, smpOR, smpNOT : gate stage outputs being checked
//   busy                  : high whenever not idle
//   done                  : one-cycle pulse in the final cycle of a run
//   pass                  : errCount == 0, held until the next accepted start
//   errMask               : mismatch bit per (vector, gate) at vec*3+gate
//   errCount              : total mismatches of the run (0..12)
// SETTLE_CYCLES legal range is 1..15.
module lab1_gate_checker
  import lab1_gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              drvA,
  output logic              drvB,
  input  logic              smpAND,
  input  logic              smpOR,
  input  logic              smpNOT,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MASK_W-1:0] errMask,
  output logic [3:0]        errCount
);

  // Counter runs SETTLE_CYCLES-1 down to 0, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [1:0]  vec;
  logic [3:0]  settle_cnt;

  logic [2:0]        golden;
  logic [2:0]        mismatch;
  logic [MASK_W-1:0] vec_mask;
  logic [3:0]        count_next;

  lab1_gate_checker_golden u_golden (
    .a        (drvA),
    .b        (drvB),
    .expected (golden)
  );

  assign mismatch   = {smpNOT, smpOR, smpAND} ^ golden;
  assign count_next = errCount + count_ones3(mismatch);

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path through the block infers a latch.
  always_comb begin
    vec_mask = '0;
    vec_mask[int'(vec) * NUM_GATES +: NUM_GATES] = mismatch;
  end

  // NOTE: all state lives in this one clocked block and is written with
  // non-blocking assignments, so every right-hand side sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      drvA       <= 1'b0;
      drvB       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      errMask    <= '0;
      errCount   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            errMask    <= '0;
            errCount   <= '0;
            pass       <= 1'b0;
            vec        <= '0;
            drvA       <= 1'b0;
            drvB       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_CHECK: begin
          errMask  <= errMask | vec_mask;
          errCount <= count_next;
          if (vec == LAST_VEC) begin
            // Result is published together with the done pulse.
            done  <= 1'b1;
            pass  <= (count_next == '0);
            state <= ST_DONE;
          end else begin
            vec          <= vec + 2'd1;
            {drvA, drvB} <= vec + 2'd1;
            settle_cnt   <= SETTLE_LOAD;
            state        <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_gate_checker.sv
// Bench for lab1_gate_checker: two instances (SETTLE_CYCLES=2 and 1), each
// driving a behavioural gate stage whose faults are chosen by `mode`
// (0 = correct, 1 = OR output stuck at 0, 2 = NOT output wired to A).
module tb_lab1_gate_checker;

  typedef struct {
    logic        pass;
    logic [11:0] mask;
    logic [3:0]  cnt;
  } result_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic sel;
  int   mode;

  int checks   = 0;
  int failures = 0;

  result_t sb[$];

  // Instance 0: default settle time.
  logic        drvA0, drvB0, busy0, done0, pass0;
  logic [11:0] errMask0;
  logic [3:0]  errCount0;
  logic        smpAND0, smpOR0, smpNOT0;

  // Instance 1: SETTLE_CYCLES = 1.
  logic        drvA1, drvB1, busy1, done1, pass1;
  logic [11:0] errMask1;
  logic [3:0]  errCount1;
  logic        smpAND1, smpOR1, smpNOT1;

  assign smpAND0 = drvA0 & drvB0;
  assign smpOR0  = (mode == 1) ? 1'b0 : (drvA0 | drvB0);
  assign smpNOT0 = (mode == 2) ? drvA0 : ~drvA0;

  assign smpAND1 = drvA1 & drvB1;
  assign smpOR1  = (mode == 1) ? 1'b0 : (drvA1 | drvB1);
  assign smpNOT1 = (mode == 2) ? drvA1 : ~drvA1;

  lab1_gate_checker #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .start    (start & ~sel),
    .drvA     (drvA0),
    .drvB     (drvB0),
    .smpAND   (smpAND0),
    .smpOR    (smpOR0),
    .smpNOT   (smpNOT0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .errMask  (errMask0),
    .errCount (errCount0)
  );

  lab1_gate_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start & sel),
    .drvA     (drvA1),
    .drvB     (drvB1),
    .smpAND   (smpAND1),
    .smpOR    (smpOR1),
    .smpNOT   (smpNOT1),
    .busy     (busy1),
    .done     (done1),
    .pass     (pass1),
    .errMask  (errMask1),
    .errCount (errCount1)
  );

  // Observed view of the selected instance.
  logic [1:0]  o_drv;
  logic        o_busy, o_done, o_pass;
  logic [11:0] o_mask;
  logic [3:0]  o_cnt;

  assign o_drv  = sel ? {drvA1, drvB1} : {drvA0, drvB0};
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_mask = sel ? errMask1 : errMask0;
  assign o_cnt  = sel ? errCount1 : errCount0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drv"},  32'(o_drv),  0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_pass"}, 32'(o_pass), 0);
    check({tag, "_mask"}, 32'(o_mask), 0);
    check({tag, "_cnt"},  32'(o_cnt),  0);
  endtask

  task automatic check_result(input string tag, input result_t e);
    check({tag, "_pass"}, 32'(o_pass), 32'(e.pass));
    check({tag, "_mask"}, 32'(o_mask), 32'(e.mask));
    check({tag, "_cnt"},  32'(o_cnt),  32'(e.cnt));
  endtask

  // One run on the selected instance; s is its SETTLE_CYCLES.
  task automatic run_one(input string tag, input int m, input int s,
                         input logic ep, input logic [11:0] em,
                         input logic [3:0] ec);
    result_t e;
    int      n;
    bit      got;
    mode   = m;
    e.pass = ep;
    e.mask = em;
    e.cnt  = ec;
    sb.push_back(e);
    start = 1'b1;
    tick();                       // edge E0 accepts the run
    start = 1'b0;
    n   = 0;
    got = 0;
    while (!got && n < 64) begin
      if (n < 4 * (s + 1)) check({tag, "_drv"}, 32'(o_drv), n / (s + 1));
      check({tag, "_busy"}, 32'(o_busy), 1);
      if (o_done) begin
        got = 1;
        check({tag, "_done_edge"}, n, 4 * (s + 1));
        check_result(tag, sb.pop_front());
      end else begin
        tick();
        n++;
      end
    end
    if (!got) begin
      check({tag, "_done_timeout"}, n, 4 * (s + 1));
      void'(sb.pop_front());
    end
    tick();                       // DONE -> IDLE, results must hold
    check({tag, "_done_pulse"}, 32'(o_done), 0);
    check({tag, "_idle_busy"}, 32'(o_busy), 0);
    check({tag, "_drv_hold"}, 32'(o_drv), 3);
    check_result({tag, "_held"}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int      n;
    int      dones;
    bit      saw_done;
    result_t e;

    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    tick();
    tick();
    check_all_zero("reset0");
    sel = 1'b1;
    check_all_zero("reset1");
    sel   = 1'b0;
    reset = 1'b0;
    tick();

    // Directed runs on the default-settle instance.
    run_one("good",    0, 2, 1'b1, 12'h000, 4'd0);
    run_one("or_stk0", 1, 2, 1'b0, 12'h490, 4'd3);
    run_one("not_bad", 2, 2, 1'b0, 12'h924, 4'd4);

    // start held high: exactly two runs, done pulses 14 edges apart.
    mode   = 0;
    e.pass = 1'b1;
    e.mask = 12'h000;
    e.cnt  = 4'd0;
    sb.push_back(e);
    sb.push_back(e);
    start = 1'b1;
    tick();
    n     = 0;
    dones = 0;
    while (dones < 2 && n < 80) begin
      if (n < 12)             check("b2b_drv_run1", 32'(o_drv), n / 3);
      if (n >= 14 && n < 26)  check("b2b_drv_run2", 32'(o_drv), (n - 14) / 3);
      if (o_done) begin
        dones++;
        check_result("b2b", sb.pop_front());
        if (dones == 1) begin
          check("b2b_done1_edge", n, 12);
        end else begin
          check("b2b_done2_edge", n, 26);
          start = 1'b0;
        end
      end
      tick();
      n++;
    end
    check("b2b_done_count", dones, 2);
    start = 1'b0;
    tick();
    check("b2b_no_third_run", 32'(o_busy), 0);

    // Reset during vector 2 SETTLE with a faulty stage: partial result is lost.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("mid_drv",  32'(o_drv),  2);
    check("mid_mask", 32'(o_mask), 32'h010);
    check("mid_cnt",  32'(o_cnt),  1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_done || o_busy) saw_done = 1;
    end
    check("mid_reset_quiet", 32'(saw_done), 0);
    run_one("after_rst", 0, 2, 1'b1, 12'h000, 4'd0);

    // Short-settle instance.
    sel = 1'b1;
    tick();
    run_one("settle1",     0, 1, 1'b1, 12'h000, 4'd0);
    run_one("settle1_not", 2, 1, 1'b0, 12'h924, 4'd4);

    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
